// File: rtl/div_seq_ctrl_pkg.sv
// rtl/div_seq_ctrl_pkg.sv - shared divider state encoding and result field constants
package div_seq_ctrl_pkg;

    localparam int DIV_DATA_W = 32;
    // Remainder occupies the upper half of div_result (HI), quotient the lower half (LO).
    localparam int REM_LSB = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ZERO = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_seq_ctrl_step.sv
// rtl/div_seq_ctrl_step.sv - one restoring-division iteration: shift in a dividend bit, trial subtract
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem,
    input  logic              dvd_bit,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] rem_next,
    output logic              q_bit
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // rem < divisor on entry, so the shifted value is below 2*divisor and one extra bit suffices.
    assign shifted  = {rem, dvd_bit};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = ~diff[DATA_W];
    assign rem_next = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];

endmodule

// File: rtl/div_seq_ctrl.sv
// rtl/div_seq_ctrl.sv - sequential radix-2 DIV/DIVU unit with start/ready handshake (option: DIV_FAST_SMALL_EN)
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start_div,
    input  logic                signed_div,
    input  logic [DATA_W-1:0]   div_srca,
    input  logic [DATA_W-1:0]   div_srcb,
    input  logic                annul,
    input  logic                pipe_stall,
    output logic [2*DATA_W-1:0] div_result,
    output logic                div_ready,
    output logic                busy
);

    div_state_t          state;
    div_state_t          state_nxt;
    logic [DATA_W-1:0]   a_r;
    logic [DATA_W-1:0]   rem_r;
    logic [DATA_W-1:0]   dvd_r;
    logic [DATA_W-1:0]   dsr_r;
    logic                neg_q_r;
    logic                neg_r_r;
    logic                div0_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [2*DATA_W-1:0] result_r;
    logic [2*DATA_W-1:0] result_nxt;
    logic                ready_r;
    logic                ready_nxt;
    logic                busy_r;
    logic                busy_nxt;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W-1:0]   step_rem;
    logic                step_q;
    logic [DATA_W-1:0]   quo_raw;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic                accept;
    logic                take_short;
    logic                last_iter;

    assign abs_a = (signed_div && div_srca[DATA_W-1]) ? ('0 - div_srca) : div_srca;
    assign abs_b = (signed_div && div_srcb[DATA_W-1]) ? ('0 - div_srcb) : div_srcb;

`ifdef DIV_FAST_SMALL_EN
    // A dividend smaller in magnitude than the divisor has q=0, r=dividend; skip the iterations.
    assign take_short = (div_srcb == '0) || (abs_a < abs_b);
`else
    assign take_short = (div_srcb == '0);
`endif

    assign accept    = (state == S_IDLE) && start_div && !annul;
    assign last_iter = (cnt_r == CNT_W'(DATA_W - 1));

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem_r),
        .dvd_bit  (dvd_r[DATA_W-1]),
        .divisor  (dsr_r),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign quo_raw = {dvd_r[DATA_W-2:0], step_q};
    assign quo_fix = neg_q_r ? ('0 - quo_raw) : quo_raw;
    assign rem_fix = neg_r_r ? ('0 - step_rem) : step_rem;

    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = take_short ? S_ZERO : S_RUN;
            S_ZERO: state_nxt = S_DONE;
            S_RUN:  if (last_iter) state_nxt = S_DONE;
            S_DONE: if (!pipe_stall) state_nxt = S_IDLE;
        endcase
        if (annul) state_nxt = S_IDLE;
    end

    always_comb begin
        ready_nxt  = (state_nxt == S_DONE);
        busy_nxt   = (state_nxt != S_IDLE);
        result_nxt = result_r;
        if (!annul) begin
            if (state == S_ZERO)
                result_nxt = {a_r, div0_r ? {DATA_W{1'b1}} : {DATA_W{1'b0}}};
            else if (state == S_RUN && last_iter)
                result_nxt = {rem_fix, quo_fix};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            a_r      <= '0;
            rem_r    <= '0;
            dvd_r    <= '0;
            dsr_r    <= '0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            div0_r   <= 1'b0;
            cnt_r    <= '0;
            result_r <= '0;
            ready_r  <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            result_r <= result_nxt;
            ready_r  <= ready_nxt;
            busy_r   <= busy_nxt;
            if (accept) begin
                a_r     <= div_srca;
                rem_r   <= '0;
                dvd_r   <= abs_a;
                dsr_r   <= abs_b;
                neg_q_r <= signed_div && (div_srca[DATA_W-1] ^ div_srcb[DATA_W-1]);
                neg_r_r <= signed_div && div_srca[DATA_W-1];
                div0_r  <= (div_srcb == '0);
                cnt_r   <= '0;
            end else if (state == S_RUN && !annul) begin
                rem_r <= step_rem;
                dvd_r <= quo_raw;
                cnt_r <= cnt_r + 1'b1;
            end
        end
    end

    assign div_result = result_r;
    assign div_ready  = ready_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb/tb_div_seq_ctrl.sv - scoreboard bench for div_seq_ctrl against an arithmetic reference model
module tb_div_seq_ctrl;
    import div_seq_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start_div = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] div_srca = '0;
    logic [31:0] div_srcb = '0;
    logic        annul = 1'b0;
    logic        pipe_stall = 1'b0;
    logic [63:0] div_result;
    logic        div_ready;
    logic        busy;

    div_seq_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .start_div  (start_div),
        .signed_div (signed_div),
        .div_srca   (div_srca),
        .div_srcb   (div_srcb),
        .annul      (annul),
        .pipe_stall (pipe_stall),
        .div_result (div_result),
        .div_ready  (div_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          rise_cyc = 0;
    logic        ready_q = 1'b0;
    logic        busy_q = 1'b0;
    logic [63:0] held = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference: plain integer division with truncation toward zero on 64-bit values.
    function automatic exp_t ref_div(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        exp_t   e;
        longint sa, sb, q, r, ma, mb;
        if (b == 32'd0) begin
            e.res = {a, 32'hFFFF_FFFF};
            e.lat = 2;
            return e;
        end
        sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
        q  = sa / sb;
        r  = sa % sb;
        e.res = {r[31:0], q[31:0]};
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
`ifdef DIV_FAST_SMALL_EN
        e.lat = (ma < mb) ? 2 : 33;
`else
        e.lat = (ma < mb) ? 33 : 33;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        if (resetn) begin
            exp_t e;
            if (busy && !busy_q) rise_cyc = cyc;
            if (div_ready && !ready_q) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_ready: got result %h with no request pending", div_result);
                end else begin
                    e = exp_q.pop_front();
                    check("result", div_result, e.res);
                    check("latency", 64'(cyc - rise_cyc + 1), 64'(e.lat));
                    check("rem_field", 64'(div_result[63:REM_LSB]), 64'(e.res[63:REM_LSB]));
                end
            end else if (div_ready && ready_q) begin
                check("held_result", div_result, held);
            end
            ready_q = div_ready;
            busy_q  = busy;
            held    = div_result;
        end
    end

    function automatic logic [31:0] pick_val();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 300));
            2:       return 32'h0 - 32'($urandom_range(1, 300));
            default: return $urandom;
        endcase
    endfunction

    task automatic wait_ready(output bit ok);
        int n = 0;
        ok = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (busy) begin
                div_srca = $urandom;
                div_srcb = $urandom;
            end
        end while (!div_ready && n < 100);
        if (!div_ready) begin
            ok = 1'b0;
            tests++;
            fails++;
            $display("FAIL ready_timeout: got no ready after %0d cycles, expected ready", n);
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn, input int stall);
        bit ok;
        exp_q.push_back(ref_div(a, b, sgn));
        @(posedge clk); #1;
        start_div = 1'b1; signed_div = sgn; div_srca = a; div_srcb = b;
        pipe_stall = (stall > 0);
        wait_ready(ok);
        if (ok) begin
            if (stall > 0) begin
                repeat (stall - 1) @(negedge clk);
                check("ready_in_stall", 64'(div_ready), 64'd1);
                @(posedge clk); #1;
                pipe_stall = 1'b0;
            end
            // start stays high across the exit edge: DONE must not accept it.
            @(posedge clk); #1;
            start_div = 1'b0;
            @(negedge clk);
            check("exit_ready", 64'(div_ready), 64'd0);
            check("exit_busy", 64'(busy), 64'd0);
        end else begin
            start_div = 1'b0;
            pipe_stall = 1'b0;
        end
    endtask

    initial begin
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", 64'(div_ready), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_result", div_result, 64'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        run_op(32'd7, 32'd2, 1'b0, 0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        run_op(32'd5, 32'd0, 1'b0, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        run_op(32'd3, 32'd9, 1'b0, 0);
        run_op(32'hFFFF_FFFD, 32'd9, 1'b1, 2);

        // Abort an operation mid-run; no result may appear.
        @(posedge clk); #1;
        start_div = 1'b1; signed_div = 1'b0; div_srca = 32'd12345; div_srcb = 32'd3;
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("annul_busy_before", 64'(busy), 64'd1);
        @(posedge clk); #1;
        annul = 1'b1; start_div = 1'b0;
        @(posedge clk); #1;
        annul = 1'b0;
        @(negedge clk);
        check("annul_busy", 64'(busy), 64'd0);
        check("annul_ready", 64'(div_ready), 64'd0);
        run_op(32'd100, 32'd7, 1'b0, 0);

        // Ready reached while stalled, start already dropped: held for 4 cycles.
        exp_q.push_back(ref_div(32'd1000, 32'd33, 1'b0));
        @(posedge clk); #1;
        start_div = 1'b1; signed_div = 1'b0; div_srca = 32'd1000; div_srcb = 32'd33;
        @(posedge clk); #1;
        start_div = 1'b0; pipe_stall = 1'b1;
        wait_ready(ok);
        repeat (3) @(negedge clk);
        check("stall_hold_ready", 64'(div_ready), 64'd1);
        check("stall_hold_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        pipe_stall = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_release_busy", 64'(busy), 64'd0);
        check("stall_release_ready", 64'(div_ready), 64'd0);

        for (int i = 0; i < 40; i++)
            run_op(pick_val(), pick_val(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
